// File: rtl/ppa_sub_pipe.sv
// Two-stage streaming subtractor: diff = a - b - bin, computed as a + ~b + ~bin
// with a Sklansky parallel-prefix carry tree between the operand and result registers.
module ppa_sub_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             vld_p1;
  logic [WIDTH-1:0] p_p1;
  logic [WIDTH-1:0] g_p1;
  logic             cin_p1;
  logic             a_msb_p1;
  logic             b_msb_p1;
  logic             vld_p2;
  logic             adv2;

  logic [WIDTH-1:0] gt;
  logic [WIDTH-1:0] pt;
  logic [WIDTH-1:0] gn;
  logic [WIDTH-1:0] pn;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  // Output stage can take new data when empty or being drained; S1 may load whenever
  // it is empty or its contents move to S2 on the same edge.
  assign adv2      = ~vld_p2 | out_ready;
  assign in_ready  = ~vld_p1 | adv2;
  assign out_valid = vld_p2;

  // Stage 1: per-bit propagate/generate of a + ~b, carry-in ~bin
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      p_p1     <= '0;
      g_p1     <= '0;
      cin_p1   <= 1'b0;
      a_msb_p1 <= 1'b0;
      b_msb_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        p_p1     <= a ^ ~b;
        g_p1     <= a & ~b;
        cin_p1   <= ~bin;
        a_msb_p1 <= a[WIDTH-1];
        b_msb_p1 <= b[WIDTH-1];
      end
    end
  end

  // Carry-in is folded into bit 0 so every prefix G[i:0] is directly carry c_{i+1}.
  // At level lvl, each bit with index bit lvl set merges with the top of the lower half-block.
  always_comb begin
    gt    = g_p1;
    pt    = p_p1;
    gt[0] = g_p1[0] | (p_p1[0] & cin_p1);
    gn    = gt;
    pn    = pt;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      gn = gt;
      pn = pt;
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> lvl) & 1) == 1) begin
          gn[i] = gt[i] | (pt[i] & gt[((i >> lvl) << lvl) - 1]);
          pn[i] = pt[i] & pt[((i >> lvl) << lvl) - 1];
        end
      end
      gt = gn;
      pt = pn;
    end
    carry = {gt, cin_p1};
    sum   = p_p1 ^ carry[WIDTH-1:0];
  end

  // Stage 2: registered result and flags, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        diff <= sum;
        bout <= ~carry[WIDTH];
        ovf  <= (a_msb_p1 != b_msb_p1) && (sum[WIDTH-1] != a_msb_p1);
        zero <= (sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_ppa_sub_pipe.sv
// Directed and randomized checks of ppa_sub_pipe at WIDTH=4, with a WIDTH=13
// instance sharing the handshake during the random stream.
module tb_ppa_sub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, bin, bin13;
  logic [3:0]  a, b;
  logic [12:0] a13, b13;
  logic        in_ready, out_valid, bout, ovf, zero;
  logic [3:0]  diff;
  logic        in_ready13, out_valid13, bout13, ovf13, zero13;
  logic [12:0] diff13;

  int n_cmp = 0;
  int n_fail = 0;

  ppa_sub_pipe #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  ppa_sub_pipe #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready13),
    .a(a13), .b(b13), .bin(bin13), .out_valid(out_valid13), .out_ready(out_ready),
    .diff(diff13), .bout(bout13), .ovf(ovf13), .zero(zero13)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: {bout, ovf, zero, diff}
  function automatic logic [6:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] r;
    r = {1'b0, x} - {1'b0, y} - {4'b0, c};
    return {r[4], (x[3] != y[3]) && (r[3] != x[3]), r[3:0] == 4'd0, r[3:0]};
  endfunction

  function automatic logic [15:0] model13(input logic [12:0] x, input logic [12:0] y, input logic c);
    logic [13:0] r;
    r = {1'b0, x} - {1'b0, y} - {13'b0, c};
    return {r[13], (x[12] != y[12]) && (r[12] != x[12]), r[12:0] == 13'd0, r[12:0]};
  endfunction

  // One isolated transaction with out_ready high; obs = {valid at N+1, valid at N+2, diff, bout, ovf, zero}
  task automatic run_vec(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                         output logic [8:0] obs);
    @(posedge clk); #1;
    in_valid = 1'b1; a = va; b = vb; bin = vbin; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    obs[8] = out_valid;
    @(posedge clk);
    @(negedge clk);
    obs[7:0] = {out_valid, diff, bout, ovf, zero};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, diff, bout, ovf, zero} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 00000000", {out_valid, diff, bout, ovf, zero});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    n_cmp++;
    if ({out_valid13, diff13, bout13, ovf13, zero13} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs13: got %h, expected 0", {out_valid13, diff13, bout13, ovf13, zero13});
    end
  endtask

  task automatic test_sub_basic;
    logic [8:0] obs;
    run_vec(4'd5, 4'd3, 1'b0, obs);
    n_cmp++;
    if (obs !== 9'b0_1_0010_000) begin
      n_fail++;
      $display("FAIL sub_5_3: got %b, expected 010010000", obs);
    end
    run_vec(4'd15, 4'd0, 1'b1, obs);
    n_cmp++;
    if (obs !== 9'b0_1_1110_000) begin
      n_fail++;
      $display("FAIL sub_15_0_bin: got %b, expected 011110000", obs);
    end
  endtask

  task automatic test_borrow_ovf;
    logic [8:0] obs;
    run_vec(4'd3, 4'd5, 1'b0, obs);
    n_cmp++;
    if (obs !== 9'b0_1_1110_100) begin
      n_fail++;
      $display("FAIL borrow_3_5: got %b, expected 011110100", obs);
    end
    run_vec(4'd8, 4'd1, 1'b0, obs);
    n_cmp++;
    if (obs !== 9'b0_1_0111_010) begin
      n_fail++;
      $display("FAIL ovf_8_1: got %b, expected 010111010", obs);
    end
    run_vec(4'd7, 4'd8, 1'b0, obs);
    n_cmp++;
    if (obs !== 9'b0_1_1111_110) begin
      n_fail++;
      $display("FAIL ovf_7_8: got %b, expected 011111110", obs);
    end
  endtask

  task automatic test_edge_zero;
    logic [8:0] obs;
    run_vec(4'd0, 4'd15, 1'b1, obs);
    n_cmp++;
    if (obs !== 9'b0_1_0000_101) begin
      n_fail++;
      $display("FAIL zero_0_15_bin: got %b, expected 010000101", obs);
    end
    run_vec(4'd9, 4'd9, 1'b0, obs);
    n_cmp++;
    if (obs !== 9'b0_1_0000_001) begin
      n_fail++;
      $display("FAIL zero_9_9: got %b, expected 010000001", obs);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] va [6] = '{4'd5, 4'd3, 4'd8, 4'd0, 4'd9, 4'd12};
    logic [3:0] vb [6] = '{4'd3, 4'd5, 4'd1, 4'd15, 4'd9, 4'd4};
    logic       vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] ed [6] = '{4'd2, 4'd14, 4'd7, 4'd0, 4'd0, 4'd7};
    logic       eb [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int acc = 0;
    int pops = 0;
    logic step;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; a = va[0]; b = vb[0]; bin = vc[0];
    for (int cyc = 0; cyc < 40 && pops < 6; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b01) begin
          n_fail++;
          $display("FAIL stall_full: in_ready,out_valid got %b, expected 01", {in_ready, out_valid});
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if ({bout, diff} !== {eb[pops], ed[pops]}) begin
          n_fail++;
          $display("FAIL stream_item%0d: got bout=%b diff=%h, expected bout=%b diff=%h",
                   pops, bout, diff, eb[pops], ed[pops]);
        end
        pops++;
      end else if (out_valid) begin
        n_cmp++;
        if (diff !== ed[pops]) begin
          n_fail++;
          $display("FAIL stall_hold: got diff=%h, expected %h", diff, ed[pops]);
        end
      end
      step = in_valid && in_ready;
      @(posedge clk); #1;
      if (step) acc++;
      in_valid = (acc < 6);
      if (acc < 6) begin
        a = va[acc]; b = vb[acc]; bin = vc[acc];
      end
      out_ready = ((cyc + 1) >= 3);
    end
    n_cmp++;
    if (pops !== 6 || acc !== 6) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results / %0d accepts, expected 6 / 6", pops, acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_full;
    logic [8:0] obs;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; a = 4'd1; b = 4'd1; bin = 1'b0;
    @(posedge clk); #1;
    a = 4'd2;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL prereset_full: in_ready,out_valid got %b, expected 01", {in_ready, out_valid});
    end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 4'd7;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, diff, bout, ovf, zero} !== 9'b1_0_0000_000) begin
      n_fail++;
      $display("FAIL reset_full: got %b, expected 100000000", {in_ready, out_valid, diff, bout, ovf, zero});
    end
    run_vec(4'd6, 4'd2, 1'b1, obs);
    n_cmp++;
    if (obs !== 9'b0_1_0011_000) begin
      n_fail++;
      $display("FAIL after_reset_6_2: got %b, expected 010011000", obs);
    end
  endtask

  task automatic test_random;
    logic [6:0]  q4[$];
    logic [15:0] q13[$];
    logic [6:0]  e4;
    logic [15:0] e13;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 3020; cyc++) begin
      if (cyc < 3000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
        a13 = 13'($urandom); b13 = 13'($urandom); bin13 = 1'($urandom);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q4.size() == 0) begin
          n_fail++;
          $display("FAIL rand4_extra: unexpected result diff=%h at cycle %0d", diff, cyc);
        end else begin
          e4 = q4.pop_front();
          if ({bout, ovf, zero, diff} !== e4) begin
            n_fail++;
            $display("FAIL rand4: got %b, expected %b at cycle %0d", {bout, ovf, zero, diff}, e4, cyc);
          end
        end
      end
      if (out_valid13 && out_ready) begin
        n_cmp++;
        if (q13.size() == 0) begin
          n_fail++;
          $display("FAIL rand13_extra: unexpected result diff=%h at cycle %0d", diff13, cyc);
        end else begin
          e13 = q13.pop_front();
          if ({bout13, ovf13, zero13, diff13} !== e13) begin
            n_fail++;
            $display("FAIL rand13: got %h, expected %h at cycle %0d",
                     {bout13, ovf13, zero13, diff13}, e13, cyc);
          end
        end
      end
      if (in_valid && in_ready) q4.push_back(model4(a, b, bin));
      if (in_valid && in_ready13) q13.push_back(model13(a13, b13, bin13));
      @(posedge clk); #1;
    end
    n_cmp++;
    if (q4.size() != 0 || q13.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d / %0d results never arrived, expected 0 / 0", q4.size(), q13.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0; a13 = '0; b13 = '0; bin13 = 1'b0;
    test_reset;
    test_sub_basic;
    test_borrow_ovf;
    test_edge_zero;
    test_back_to_back;
    test_reset_full;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
